// File: rtl/tft_pkg.sv
// Shared types and default timing for the TFT timing generator: power states,
// test-pattern encodings and the 480x272 panel timing.
package tft_pkg;

  typedef enum logic [1:0] {
    PWR_OFF  = 2'd0,
    PWR_VDD  = 2'd1,
    PWR_DISP = 2'd2,
    PWR_RUN  = 2'd3
  } pwr_state_e;

  localparam logic [1:0] PAT_PASS  = 2'd0;
  localparam logic [1:0] PAT_WHITE = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_GRAD  = 2'd3;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FRONT  = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BACK   = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FRONT  = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BACK   = 4;

endpackage

// File: rtl/tft_timing_gen_if.sv
// Panel-side pin bundle of the TFT timing generator.
// tft_data_ena is a valid qualifier for tft_red/green/blue; the panel has no ready.
interface tft_timing_gen_if #(
  parameter int COLOR_W = 8
);
  logic               tft_data_ena;
  logic               tft_hsync;
  logic               tft_vsync;
  logic [COLOR_W-1:0] tft_red;
  logic [COLOR_W-1:0] tft_green;
  logic [COLOR_W-1:0] tft_blue;
  logic               tft_vdd;
  logic               tft_display;
  logic               tft_backlight;

  modport master (
    output tft_data_ena, tft_hsync, tft_vsync, tft_red, tft_green, tft_blue,
    output tft_vdd, tft_display, tft_backlight
  );

  modport slave (
    input tft_data_ena, tft_hsync, tft_vsync, tft_red, tft_green, tft_blue,
    input tft_vdd, tft_display, tft_backlight
  );
endinterface

// File: rtl/tft_backlight_pwm.sv
// Backlight PWM: 32-bit prescaler steps an 8-bit ramp, compared against duty,
// output gated by the RUN power state.
module tft_backlight_pwm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic [31:0] freq_div_i,
  input  logic [7:0]  duty_i,
  output logic        backlight_o
);
  logic [31:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wrap;

  // >= so a lowered terminal count wraps at once instead of running to 2^32
  always_comb begin
    wrap    = (presc_q >= freq_div_i);
    presc_d = wrap ? '0 : presc_q + 32'd1;
    cnt_d   = wrap ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign backlight_o = run_i && (cnt_q < duty_i);
endmodule

// File: rtl/tft_timing_gen.sv
// TFT timing generator: x/y scan, registered DE/sync/RGB, power sequencing and
// backlight PWM. Define TFT_TEST_PATTERN_EN to build the internal test patterns.
module tft_timing_gen
  import tft_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int COLOR_W    = 8,
  parameter int PWR_FRAMES = 2,
  localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic               tft_clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [31:0]        frequency_division,
  input  logic [7:0]         duty_cycle,
  input  logic [1:0]         pattern_sel,
  input  logic [COLOR_W-1:0] pix_red,
  input  logic [COLOR_W-1:0] pix_green,
  input  logic [COLOR_W-1:0] pix_blue,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               new_frame,
  output pwr_state_e         pwr_state_o,
  tft_timing_gen_if.master   pins
);
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam int            FW       = $clog2(PWR_FRAMES) + 1;
  localparam logic [FW-1:0] PWR_LAST = FW'(PWR_FRAMES - 1);

  pwr_state_e         state_q, state_d;
  logic [FW-1:0]      frm_q, frm_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               scan_en, rgb_en, line_end, frame_end, de, hs_n, vs_n;
  logic [COLOR_W-1:0] src_r, src_g, src_b;
  logic               de_q, hs_q, vs_q, backlight;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  // Dropping enable takes effect on the very next edge, so gate with it here too
  always_comb begin
    scan_en   = (state_q != PWR_OFF) && enable;
    rgb_en    = (state_q == PWR_RUN) && enable;
    line_end  = (x_q == H_LAST);
    frame_end = line_end && (y_q == V_LAST);
    de        = (x_q < H_ACT) && (y_q < V_ACT);
    hs_n      = !((x_q >= HS_BEG) && (x_q < HS_END));
    vs_n      = !((y_q >= VS_BEG) && (y_q < VS_END));
    x_d       = '0;
    y_d       = '0;
    if (scan_en) begin
      x_d = line_end ? '0 : x_q + 1'b1;
      y_d = y_q;
      if (line_end) y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    if (!enable) begin
      state_d = PWR_OFF;
      frm_d   = '0;
    end else begin
      case (state_q)
        PWR_OFF: begin
          state_d = PWR_VDD;
          frm_d   = '0;
        end
        PWR_VDD, PWR_DISP: begin
          if (frame_end) begin
            if (frm_q == PWR_LAST) begin
              frm_d   = '0;
              state_d = (state_q == PWR_VDD) ? PWR_DISP : PWR_RUN;
            end else begin
              frm_d = frm_q + 1'b1;
            end
          end
        end
        PWR_RUN: ;
        default: state_d = PWR_OFF;
      endcase
    end
  end

  always_ff @(posedge tft_clk) begin
    if (rst) begin
      state_q <= PWR_OFF;
      frm_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      frm_q   <= frm_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

`ifdef TFT_TEST_PATTERN_EN
  localparam logic [XW-1:0] BAR_DIV = XW'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);
  logic [2:0] bar;

  always_comb begin
    bar   = 3'(x_q / BAR_DIV);
    src_r = pix_red;
    src_g = pix_green;
    src_b = pix_blue;
    case (pattern_sel)
      PAT_WHITE: begin
        src_r = '1;
        src_g = '1;
        src_b = '1;
      end
      PAT_BARS: begin
        src_r = {COLOR_W{bar[2]}};
        src_g = {COLOR_W{bar[1]}};
        src_b = {COLOR_W{bar[0]}};
      end
      PAT_GRAD: begin
        src_r = COLOR_W'(x_q);
        src_g = COLOR_W'(y_q);
        src_b = '0;
      end
      default: ;
    endcase
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^pattern_sel;

  always_comb begin
    src_r = pix_red;
    src_g = pix_green;
    src_b = pix_blue;
  end
`endif

  // Everything registered from this cycle's x/y so DE, syncs and RGB stay aligned
  always_ff @(posedge tft_clk) begin
    if (rst) begin
      de_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      de_q    <= rgb_en && de;
      hs_q    <= hs_n || !scan_en;
      vs_q    <= vs_n || !scan_en;
      red_q   <= (rgb_en && de) ? src_r : '0;
      green_q <= (rgb_en && de) ? src_g : '0;
      blue_q  <= (rgb_en && de) ? src_b : '0;
    end
  end

  tft_backlight_pwm u_pwm (
    .clk_i       (tft_clk),
    .rst_i       (rst),
    .run_i       (state_q == PWR_RUN),
    .freq_div_i  (frequency_division),
    .duty_i      (duty_cycle),
    .backlight_o (backlight)
  );

  assign x                  = x_q;
  assign y                  = y_q;
  assign new_frame          = frame_end;
  assign pwr_state_o        = state_q;
  assign pins.tft_data_ena  = de_q;
  assign pins.tft_hsync     = hs_q;
  assign pins.tft_vsync     = vs_q;
  assign pins.tft_red       = red_q;
  assign pins.tft_green     = green_q;
  assign pins.tft_blue      = blue_q;
  assign pins.tft_vdd       = (state_q != PWR_OFF);
  assign pins.tft_display   = (state_q == PWR_DISP) || (state_q == PWR_RUN);
  assign pins.tft_backlight = backlight;
endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen on a shrunken 16x6 panel: cycle model with an
// expected queue for the registered outputs plus directed timing/count checks.
module tb_tft_timing_gen;
  import tft_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PWR = 2;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  // clock / reset
  logic tft_clk = 1'b0;
  logic rst, enable;
  always #5 tft_clk = ~tft_clk;

  logic [31:0]   frequency_division;
  logic [7:0]    duty_cycle;
  logic [1:0]    pattern_sel;
  logic [7:0]    pix_red, pix_green, pix_blue;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          new_frame;
  pwr_state_e    pwr_state;

  tft_timing_gen_if #(.COLOR_W(8)) pins ();

  tft_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLOR_W(8), .PWR_FRAMES(PWR)
  ) dut (
    .tft_clk            (tft_clk),
    .rst                (rst),
    .enable             (enable),
    .frequency_division (frequency_division),
    .duty_cycle         (duty_cycle),
    .pattern_sel        (pattern_sel),
    .pix_red            (pix_red),
    .pix_green          (pix_green),
    .pix_blue           (pix_blue),
    .x                  (x),
    .y                  (y),
    .new_frame          (new_frame),
    .pwr_state_o        (pwr_state),
    .pins               (pins)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int tests_run = 0, tests_failed = 0;
  int cyc = 0;
  int m_x, m_y, m_state, m_frm, m_presc, m_cnt;
  int px, py;
  int n_de, n_hs_low, n_vs_low, n_bl, n_nf, last_nf, nf_period;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_src();
    logic [23:0] s;
`ifdef TFT_TEST_PATTERN_EN
    int b;
`endif
    s = {pix_red, pix_green, pix_blue};
`ifdef TFT_TEST_PATTERN_EN
    b = m_x / (HA / 8);
    case (pattern_sel)
      2'd1: s = 24'hffffff;
      2'd2: s = {((b & 4) != 0) ? 8'hff : 8'h00, ((b & 2) != 0) ? 8'hff : 8'h00,
                 ((b & 1) != 0) ? 8'hff : 8'h00};
      2'd3: s = {8'(m_x), 8'(m_y), 8'h00};
      default: ;
    endcase
`endif
    return s;
  endfunction

  function automatic logic [26:0] exp_pipe();
    logic scan, run, de, hs, vs;
    if (rst) return {1'b0, 1'b1, 1'b1, 24'h0};
    scan = (m_state != 0) && enable;
    run  = (m_state == 3) && enable;
    de   = run && (m_x < HA) && (m_y < VA);
    hs   = !(scan && (m_x >= HA + HF) && (m_x < HA + HF + HS));
    vs   = !(scan && (m_y >= VA + VF) && (m_y < VA + VF + VS));
    return {de, hs, vs, de ? exp_src() : 24'h0};
  endfunction

  task automatic model_step();
    logic strobe, scan;
    if (rst) begin
      m_x = 0; m_y = 0; m_state = 0; m_frm = 0; m_presc = 0; m_cnt = 0;
    end else begin
      strobe = (m_x == HT - 1) && (m_y == VT - 1);
      scan   = (m_state != 0) && enable;
      if (!enable) begin
        m_state = 0; m_frm = 0;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state < 3 && strobe) begin
        m_frm++;
        if (m_frm == PWR) begin m_frm = 0; m_state++; end
      end
      if (scan) begin
        m_x++;
        if (m_x == HT) begin
          m_x = 0; m_y++;
          if (m_y == VT) m_y = 0;
        end
      end else begin
        m_x = 0; m_y = 0;
      end
      if (m_presc >= int'(frequency_division)) begin
        m_presc = 0; m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_presc++;
      end
    end
  endtask

  // driver: one clock with stimulus, expectation push, model step and checks
  task automatic tick();
    logic [31:0] got;
    pix_red   = 8'(x);
    pix_green = 8'($urandom_range(0, 255));
    pix_blue  = 8'($urandom_range(0, 255));
    exp_q.push_back(32'(exp_pipe()));
    px = m_x; py = m_y;
    @(posedge tft_clk);
    model_step();
    #1;
    cyc++;
    got = 32'({pins.tft_data_ena, pins.tft_hsync, pins.tft_vsync,
               pins.tft_red, pins.tft_green, pins.tft_blue});
    chk("pipe", got, exp_q.pop_front());
    chk("pos", 32'({x, y, new_frame}),
        32'({XW'(m_x), YW'(m_y), (m_x == HT - 1) && (m_y == VT - 1)}));
    chk("pwr", 32'({pins.tft_vdd, pins.tft_display, pins.tft_backlight}),
        32'({m_state != 0, m_state >= 2, (m_state == 3) && (m_cnt < int'(duty_cycle))}));
    if (pins.tft_data_ena) n_de++;
    if (!pins.tft_hsync) n_hs_low++;
    if (!pins.tft_vsync) n_vs_low++;
    if (pins.tft_backlight) n_bl++;
    if (new_frame) begin
      n_nf++;
      if (last_nf >= 0) nf_period = cyc - last_nf;
      last_nf = cyc;
    end
  endtask

  task automatic bl_window(input int dc, input int fd, input int n, input int exp_hi);
    duty_cycle = 8'(dc);
    frequency_division = 32'(fd);
    n_bl = 0;
    repeat (n) tick();
    chk("bl_count", 32'(n_bl), 32'(exp_hi));
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_vdd, t_disp, t_run;
    rst = 1'b1; enable = 1'b0;
    frequency_division = 32'd0; duty_cycle = 8'd64; pattern_sel = 2'd0;
    pix_red = '0; pix_green = '0; pix_blue = '0;
    m_x = 0; m_y = 0; m_state = 0; m_frm = 0; m_presc = 0; m_cnt = 0;
    n_de = 0; n_hs_low = 0; n_vs_low = 0; n_bl = 0; n_nf = 0;
    last_nf = -1; nf_period = 0;

    tick(); tick();
    chk("rst_state", 32'(pwr_state), 32'(PWR_OFF));

    // power-up sequence
    rst = 1'b0; enable = 1'b1;
    t0 = cyc; t_vdd = -1; t_disp = -1; t_run = -1;
    for (int i = 0; i < 3 * PWR * FT && pwr_state != PWR_RUN; i++) begin
      tick();
      if (t_vdd < 0 && pins.tft_vdd) t_vdd = cyc - t0;
      if (t_disp < 0 && pins.tft_display) t_disp = cyc - t0;
      if (t_run < 0 && pwr_state == PWR_RUN) t_run = cyc - t0;
    end
    chk("t_vdd", 32'(t_vdd), 32'd1);
    chk("t_disp", 32'(t_disp), 32'(PWR * FT + 1));
    chk("t_run", 32'(t_run), 32'(2 * PWR * FT + 1));

    // one full frame in RUN with pix_red tracking x
    n_de = 0; n_hs_low = 0; n_vs_low = 0; n_nf = 0;
    repeat (FT) begin
      tick();
      if (pins.tft_data_ena) chk("red_is_x", 32'(pins.tft_red), 32'(px));
    end
    chk("de_per_frame", 32'(n_de), 32'(HA * VA));
    chk("hs_low_per_frame", 32'(n_hs_low), 32'(HS * VT));
    chk("vs_low_per_frame", 32'(n_vs_low), 32'(VS * HT));
    chk("nf_per_frame", 32'(n_nf), 32'd1);
    chk("nf_period", 32'(nf_period), 32'(FT));

    // backlight PWM
    bl_window(64, 0, 256, 64);
    bl_window(0, 0, 256, 0);
    bl_window(255, 0, 256, 255);
    bl_window(64, 1, 512, 128);
    frequency_division = 32'd0; duty_cycle = 8'd128;

    // pattern select sweep (pass-through when patterns are not built)
    for (int s = 1; s < 4; s++) begin
      pattern_sel = 2'(s);
      repeat (FT) begin
        tick();
`ifdef TFT_TEST_PATTERN_EN
        if (s == 2 && py < VA && px == HA / 8)
          chk("bar1", 32'({pins.tft_red, pins.tft_green, pins.tft_blue}), 32'h0000ff);
        if (s == 2 && py < VA && px == 7 * HA / 8)
          chk("bar7", 32'({pins.tft_red, pins.tft_green, pins.tft_blue}), 32'hffffff);
`endif
      end
    end
    pattern_sel = 2'd0;

    // enable dropped mid-frame
    for (int i = 0; i < 2 * FT && !(m_x == 10 && m_y == 3); i++) tick();
    enable = 1'b0;
    tick();
    chk("drop_xy", 32'({x, y}), 32'd0);
    chk("drop_pwr", 32'({pins.tft_vdd, pins.tft_display, pins.tft_backlight}), 32'd0);
    chk("drop_rgb", 32'({pins.tft_red, pins.tft_green, pins.tft_blue}), 32'd0);

    // reset mid-frame while powering up
    enable = 1'b1;
    repeat (FT + 40) tick();
    for (int i = 0; i < 2 * FT && !(m_x == 10 && m_y == 3); i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_xy", 32'({x, y, new_frame}), 32'd0);
    chk("rst_pins", 32'({pins.tft_data_ena, pins.tft_hsync, pins.tft_vsync,
                         pins.tft_red, pins.tft_green, pins.tft_blue}), 32'(27'h3 << 24));
    chk("rst_pwr", 32'({pins.tft_vdd, pins.tft_display, pins.tft_backlight}), 32'd0);
    chk("rst_fsm", 32'(pwr_state), 32'(PWR_OFF));
    rst = 1'b0; enable = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/tft_timing_gen.md
# tft_timing_gen

Parametrised successor to the lab TFT driver: generates pixel coordinates, data-enable, sync, and frame strobe for an arbitrary-timing RGB TFT panel. It also sequences panel power (vdd → display → backlight) and drives an 8-bit PWM backlight. A framebuffer or pattern source is fed from `x`/`y` one cycle ahead of the registered RGB outputs. The block sits between the pixel source and the panel pins and runs entirely in the `tft_clk` domain.

## Interface
Reset is synchronous, active-high, on a single clock (`tft_clk`).

Parameters:
- H_ACTIVE, 480: visible pixels per line
- H_FRONT, 2 / H_SYNC, 41 / H_BACK, 2: horizontal porches and sync width; H_TOTAL = sum = 525
- V_ACTIVE, 272: visible lines
- V_FRONT, 2 / V_SYNC, 10 / V_BACK, 4: vertical porches and sync width; V_TOTAL = 288
- COLOR_W, 8: bits per colour channel
- PWR_FRAMES, 2: frames spent in each power-up step, ≥1

Ports:
- tft_clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- enable  in  1  1 = power up and scan; 0 = immediate power-down
- frequency_division  in  32  PWM prescaler terminal count
- duty_cycle  in  8  backlight duty, n/256
- pattern_sel  in  2  test pattern select (see Configuration)
- pix_red/pix_green/pix_blue  in  COLOR_W  pixel for current `x`/`y`
- x  out  XW=$clog2(H_TOTAL)  horizontal counter
- y  out  YW=$clog2(V_TOTAL)  vertical counter
- new_frame  out  1  one-cycle frame strobe
- tft_data_ena  out  1  RGB valid
- tft_hsync/tft_vsync  out  1  active-low syncs
- tft_red/tft_green/tft_blue  out  COLOR_W  registered pixel
- tft_vdd, tft_display, tft_backlight  out  1  panel power controls

## Operation
- Counters: `x` counts 0..H_TOTAL-1 and wraps. On wrap, `y` increments, wrapping at V_TOTAL-1. Line order: active, front, sync, back.
- Internal `de` = (x<H_ACTIVE)&&(y<V_ACTIVE).
- Syncs are low while x∈[H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). The same rule applies to `y` with the V parameters.
- new_frame: high for the single cycle where x=H_TOTAL-1 and y=V_TOTAL-1.
- Power FSM: OFF → VDD → DISP → RUN.
  - OFF: counters held at 0; all panel outputs 0.
  - OFF → VDD when enable=1.
  - VDD: tft_vdd=1; counters run. Advances after PWR_FRAMES new_frame strobes.
  - DISP: tft_display=1; advances after PWR_FRAMES strobes.
  - RUN: backlight PWM live; RGB live.
  - enable=0 in any state → OFF next cycle. Counters reset to 0 and the frame count clears.
- RGB: outside RUN, or when `de`=0, RGB registers load 0.
- PWM: a 32-bit prescaler counts 0..frequency_division. On each wrap, an 8-bit pwm_cnt increments (mod 256).
  - tft_backlight = RUN && (pwm_cnt < duty_cycle).
  - duty_cycle=0 → always off; 255 → high 255 of every 256 steps.
  - A frequency_division change takes effect at the next compare.
- Reset values: x=0, y=0, new_frame=0, tft_data_ena=0, hsync=vsync=1, RGB=0, tft_vdd=tft_display=tft_backlight=0, FSM=OFF, prescaler=pwm_cnt=0.

## Timing
- Pixel latency is 1 cycle: `pix_*` sampled with `x`/`y` in cycle N appears on `tft_*` in cycle N+1.
- tft_data_ena, tft_hsync, and tft_vsync are likewise registered from cycle-N `x`/`y`, so all panel outputs align.
- Frame = H_TOTAL×V_TOTAL cycles (151200 at defaults). new_frame recurs exactly every frame.
- Power-up: enable rising at cycle 0 gives:
  - tft_vdd=1 at cycle 1
  - tft_display=1 one cycle after the PWR_FRAMES-th strobe
  - RUN one cycle after the 2·PWR_FRAMES-th strobe
- rst beats enable. Reset mid-frame returns every output to its reset value on the next edge.

## Configuration
- TFT_TEST_PATTERN_EN defined:
  - pattern_sel=0: pixel inputs pass through
  - pattern_sel=1: all channels at full scale (solid white)
  - pattern_sel=2: 8 vertical bars, each H_ACTIVE/8 wide. Bar index b sets red=b[2], green=b[1], blue=b[0] at full scale.
  - pattern_sel=3: gradient, red=x[COLOR_W-1:0], green=y[COLOR_W-1:0], blue=0.
- Undefined: pattern_sel is ignored, pixel inputs always pass through, and no pattern logic is synthesised.

## Structure
- Package tft_pkg holds:
  - the power-state enum (OFF/VDD/DISP/RUN)
  - the pattern_sel encodings
  - default 480×272 timing constants
- One sub-module: tft_backlight_pwm (prescaler, pwm_cnt, compare, run gate).

## Test plan
- Defaults, rst 2 cycles then enable=1 → tft_vdd=1 one cycle after rst low. Display after 2 frames; RUN after 4. new_frame period = 151200 cycles.
- In RUN, count tft_data_ena highs per frame → 480 per line, 272 lines, total 130560. hsync low exactly 41 cycles per line; vsync low exactly 10 lines.
- pix_red=x[7:0] → tft_red in cycle N+1 equals x from cycle N; RGB=0 during blanking.
- frequency_division=0, duty_cycle=64 → tft_backlight high 64 of every 256 cycles. duty_cycle=0 → never high.
- enable dropped mid-frame at x=100, y=50 → next cycle x=y=0 and all power outputs and RGB are 0. rst mid-frame gives the same result.
- TFT_TEST_PATTERN_EN, pattern_sel=2 → at x=60 (bar 1) tft_blue=255 and red=green=0; at x=420 (bar 7) all channels are 255.
